text_injector: RTL and testbench

Replays a host-downloaded text file into the Apple-1 keyboard register pair (KBD at 0xD010, KBDCR at 0xD011), one character per CPU keyboard poll, so BASIC listings and WozMon hex dumps can be pasted without typing. It sits beside the PS/2 and UART receivers on the CPU's `rx_cs` decode. Its `data_ready` output steers the top-level data-in mux to this block whenever a pasted character is pending.

---
 rtl/apple1_pkg.sv | 24 ++
 rtl/text_buffer.sv | 30 +++
 rtl/text_injector.sv | 184 ++++++++++++++++++
 tb/tb_text_injector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared Apple-1 keyboard constants and the paste-injector state type.
//   KBD_ADDR / KBDCR_ADDR : keyboard data and control register addresses
//   ASCII_*               : 7-bit control codes the translator cares about
//   inj_state_t           : text_injector FSM states
package apple1_pkg;

  localparam logic [15:0] KBD_ADDR   = 16'hD010;
  localparam logic [15:0] KBDCR_ADDR = 16'hD011;

  localparam logic [6:0] ASCII_CR  = 7'h0D;
  localparam logic [6:0] ASCII_LF  = 7'h0A;
  localparam logic [6:0] ASCII_ESC = 7'h1B;
  localparam logic [6:0] ASCII_DEL = 7'h7F;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    XLATE,
    PRESENT,
    PACE
  } inj_state_t;

endpackage

// File: rtl/text_buffer.sv
// Simple dual-port byte RAM holding the downloaded text file.
//   clk25     : clock
//   wrEn_i    : write strobe
//   wrAddr_i  : write address
//   wrData_i  : write byte
//   rdAddr_i  : read address, sampled every clock
//   rdData_o  : registered read byte (one-cycle latency)
// No reset on the array or read register so the tools can map it to block RAM.
module text_buffer #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk25,
  input  logic                  wrEn_i,
  input  logic [DEPTH_LOG2-1:0] wrAddr_i,
  input  logic [7:0]            wrData_i,
  input  logic [DEPTH_LOG2-1:0] rdAddr_i,
  output logic [7:0]            rdData_o
);

  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Write port and registered read port share the one clock.
  always_ff @(posedge clk25) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/text_injector.sv
// Replays a host-downloaded text file into the Apple-1 KBD/KBDCR register
// pair, one translated character per CPU keyboard read.
//   clk25, rst                 : 25 MHz clock, async active-high reset
//   enable                     : CPU clock enable, qualifies register reads
//   cs, address                : keyboard register select; address 0=KBD, 1=KBDCR
//   ioctl_download, ioctl_wr   : host download window and byte strobe
//   textinput_addr/_dout       : byte offset and byte value of the file
//   dout                       : register read data
//   data_ready                 : a character is waiting for the CPU
//   busy                       : loading or replaying
module text_injector
  import apple1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int CR_DELAY   = 250000,
  parameter int CHAR_DELAY = 2500
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        enable,
  input  logic        cs,
  input  logic        address,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] textinput_addr,
  input  logic [7:0]  textinput_dout,
  output logic [7:0]  dout,
  output logic        data_ready,
  output logic        busy
);

  localparam int LenW     = DEPTH_LOG2 + 1;
  localparam int MaxDelay = (CR_DELAY > CHAR_DELAY) ? CR_DELAY : CHAR_DELAY;
  localparam int PaceW    = $clog2(MaxDelay + 1);
  localparam logic [16:0] BufSize = 17'(1) << DEPTH_LOG2;

  // Returns {skip, c}: the first matching rule wins, LF folds into CR
  // unless it directly follows a CR (CR/LF pairs become a single return).
  function automatic logic [7:0] xlate(input logic [7:0] raw, input logic prevCr);
    logic [6:0] c;
    logic       skip;
    c    = 7'(raw & 8'h7F);
    skip = 1'b0;
    if (c == ASCII_LF) begin
      if (prevCr) skip = 1'b1;
      else        c = ASCII_CR;
    end else if (c >= 7'h61 && c <= 7'h7A) begin
      c = c - 7'h20;
    end else if (c < 7'h20 && c != ASCII_CR && c != ASCII_ESC) begin
      skip = 1'b1;
    end else if (c == ASCII_DEL) begin
      skip = 1'b1;
    end
    return {skip, c};
  endfunction

  inj_state_t       state_q, state_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [LenW-1:0]  rdPtr_q, rdPtr_d;
  logic [PaceW-1:0] paceCnt_q, paceCnt_d;
  logic [7:0]       kbd_q, kbd_d;
  logic             ready_q, ready_d;
  logic             prevCr_q, prevCr_d;
  logic             truncated_q, truncated_d;

  logic             wrEn;
  logic [7:0]       rdData;
  logic [7:0]       xlated;
  logic [LenW-1:0]  wrLen;
  logic             consume;

  text_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
    .clk25    (clk25),
    .wrEn_i   (wrEn),
    .wrAddr_i (textinput_addr[DEPTH_LOG2-1:0]),
    .wrData_i (textinput_dout),
    .rdAddr_i (rdPtr_q[DEPTH_LOG2-1:0]),
    .rdData_o (rdData)
  );

  assign xlated  = xlate(rdData, prevCr_q);
  assign wrLen   = LenW'(textinput_addr[DEPTH_LOG2-1:0]) + LenW'(1);
  assign consume = cs & enable & ~address;

  // State and datapath registers.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rdPtr_q     <= '0;
      paceCnt_q   <= '0;
      kbd_q       <= '0;
      ready_q     <= 1'b0;
      prevCr_q    <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rdPtr_q     <= rdPtr_d;
      paceCnt_q   <= paceCnt_d;
      kbd_q       <= kbd_d;
      ready_q     <= ready_d;
      prevCr_q    <= prevCr_d;
      truncated_q <= truncated_d;
    end
  end

  // Next-state logic. The RAM read address is always rdPtr_q, so the byte
  // fetched in FETCH is on rdData during XLATE.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rdPtr_d     = rdPtr_q;
    paceCnt_d   = paceCnt_q;
    kbd_d       = kbd_q;
    ready_d     = ready_q;
    prevCr_d    = prevCr_q;
    truncated_d = truncated_q;
    wrEn        = 1'b0;

    case (state_q)
      IDLE: ;
      LOAD: begin
        if (ioctl_wr) begin
          if ({1'b0, textinput_addr} < BufSize) begin
            wrEn = 1'b1;
            if (wrLen > len_q) len_d = wrLen;
          end else begin
            truncated_d = 1'b1;
          end
        end
        // Exit decision includes a write taken in this same cycle.
        if (!ioctl_download) begin
          state_d = (len_d != '0) ? FETCH : IDLE;
        end
      end
      FETCH: begin
        if (rdPtr_q == len_q) begin
          state_d = IDLE;
        end else begin
          rdPtr_d = rdPtr_q + LenW'(1);
          state_d = XLATE;
        end
      end
      XLATE: begin
        if (xlated[7]) begin
          state_d = FETCH;
        end else begin
          kbd_d    = {1'b1, xlated[6:0]};
          prevCr_d = (xlated[6:0] == ASCII_CR);
          ready_d  = 1'b1;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (consume) begin
          ready_d   = 1'b0;
          paceCnt_d = (kbd_q[6:0] == ASCII_CR) ? PaceW'(CR_DELAY - 1)
                                               : PaceW'(CHAR_DELAY - 1);
          state_d   = PACE;
        end
      end
      PACE: begin
        if (paceCnt_q == '0) state_d = FETCH;
        else                 paceCnt_d = paceCnt_q - PaceW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A new download from idle or mid-replay restarts loading from scratch.
    if (ioctl_download && state_q != LOAD) begin
      state_d  = LOAD;
      len_d    = '0;
      rdPtr_d  = '0;
      ready_d  = 1'b0;
      prevCr_d = 1'b0;
    end
  end

  assign dout       = address ? {ready_q, 7'b0} : kbd_q;
  assign data_ready = ready_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_text_injector.sv
// Self-checking bench for text_injector (16-byte buffer, short pacing delays).
// A behavioural model turns each downloaded file into the queue of KBD bytes
// the CPU must see; a compare process checks every register read against it.
module tb_text_injector;

  localparam int DEPTH_LOG2 = 4;
  localparam int CR_DELAY   = 20;
  localparam int CHAR_DELAY = 4;
  localparam int BUF_BYTES  = 1 << DEPTH_LOG2;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cs = 1'b0;
  logic        address = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] textinput_addr = '0;
  logic [7:0]  textinput_dout = '0;
  logic [7:0]  dout;
  logic        data_ready;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  byte unsigned fileBytes[$];
  byte unsigned expQ[$];

  text_injector #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CR_DELAY   (CR_DELAY),
    .CHAR_DELAY (CHAR_DELAY)
  ) dut (
    .clk25          (clk25),
    .rst            (rst),
    .enable         (enable),
    .cs             (cs),
    .address        (address),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .textinput_addr (textinput_addr),
    .textinput_dout (textinput_dout),
    .dout           (dout),
    .data_ready     (data_ready),
    .busy           (busy)
  );

  always #20 clk25 = ~clk25;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: what the CPU must read from KBD for the current file.
  function automatic void buildExpected();
    byte unsigned ch;
    bit afterCr;
    afterCr = 1'b0;
    expQ.delete();
    for (int i = 0; i < fileBytes.size() && i < BUF_BYTES; i++) begin
      ch = fileBytes[i] & 8'h7F;
      if (ch == 8'h0A) begin
        if (afterCr) continue;
        ch = 8'h0D;
      end else if (ch >= "a" && ch <= "z") begin
        ch = ch - ("a" - "A");
      end else if ((ch < 8'h20 && ch != 8'h0D && ch != 8'h1B) || ch == 8'h7F) begin
        continue;
      end
      afterCr = (ch == 8'h0D);
      expQ.push_back(ch | 8'h80);
    end
  endfunction

  function automatic void setFile(input string s);
    fileBytes.delete();
    for (int i = 0; i < s.len(); i++) fileBytes.push_back(s[i]);
  endfunction

  // Every qualified register read is compared against the model.
  always @(negedge clk25) begin
    if (!rst && cs && enable) begin
      if (address) begin
        checkOutput("kbdcr_read", dout, 8'h80);
      end else if (expQ.size() == 0) begin
        checkOutput("kbd_unexpected", dout, 0);
        checkOutput("kbd_queue_empty", 1, 0);
      end else begin
        checkOutput("kbd_read", dout, expQ.pop_front());
      end
    end
  end

  // Streams fileBytes into the DUT; download falls after the last byte, or
  // together with it when fallWithLast is set.
  task automatic applyStimulus(input bit fallWithLast);
    if (!ioctl_download) begin
      ioctl_download = 1'b1;
      @(posedge clk25); #1;
    end
    for (int i = 0; i < fileBytes.size(); i++) begin
      ioctl_wr       = 1'b1;
      textinput_addr = 16'(i);
      textinput_dout = fileBytes[i];
      if (fallWithLast && i == fileBytes.size() - 1) ioctl_download = 1'b0;
      @(posedge clk25); #1;
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    buildExpected();
  endtask

  // Edges waited (from the current post-edge point) until data_ready is high.
  task automatic waitReady(output int waited);
    waited = 0;
    while (!data_ready && waited < 200) begin
      @(posedge clk25); #1;
      waited++;
    end
    if (!data_ready) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk25); #1;
      n++;
    end
    checkOutput("busy_idle", busy, 0);
  endtask

  // One KBDCR poll then one KBD read; the compare process checks both.
  task automatic pollAndRead();
    cs = 1'b1; enable = 1'b1; address = 1'b1;
    @(posedge clk25); #1;
    address = 1'b0;
    @(posedge clk25); #1;
    cs = 1'b0; enable = 1'b0;
    checkOutput("ready_cleared", data_ready, 0);
  endtask

  task automatic readAll(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      waitReady(w);
      pollAndRead();
    end
  endtask

  initial begin
    int w;
    byte unsigned basicExp[11];
    byte unsigned xlExp[4];
    basicExp = '{8'hB1, 8'hB0, 8'hA0, 8'hD0, 8'hD2, 8'hC9, 8'hCE, 8'hD4, 8'hA0, 8'hB1, 8'h8D};
    xlExp    = '{8'hC1, 8'hC2, 8'h8D, 8'hC3};

    // Reset state
    #5;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", data_ready, 0);
    checkOutput("rst_dout_kbd", dout, 8'h00);
    address = 1'b1; #1;
    checkOutput("rst_dout_kbdcr", dout, 8'h00);
    address = 1'b0;
    @(posedge clk25); #1;
    rst = 1'b0;
    @(posedge clk25); #1;

    // Basic replay
    setFile("10 PRINT 1\n");
    applyStimulus(1'b0);
    checkOutput("basic_len", expQ.size(), 11);
    for (int i = 0; i < 11 && i < expQ.size(); i++)
      checkOutput($sformatf("basic_model_%0d", i), expQ[i], basicExp[i]);
    waitReady(w);
    checkOutput("first_latency", w, 3);
    readAll(11);
    waitIdle();
    checkOutput("basic_drained", expQ.size(), 0);

    // Translation, last byte written in the same cycle download falls
    setFile("ab");
    fileBytes.push_back(8'h0D);
    fileBytes.push_back(8'h0A);
    fileBytes.push_back(8'h09);
    fileBytes.push_back("c");
    fileBytes.push_back(8'h7F);
    applyStimulus(1'b1);
    checkOutput("xl_len", expQ.size(), 4);
    for (int i = 0; i < 4 && i < expQ.size(); i++)
      checkOutput($sformatf("xl_model_%0d", i), expQ[i], xlExp[i]);
    readAll(4);
    waitIdle();
    checkOutput("xl_drained", expQ.size(), 0);

    // Pacing: gap counted from the edge that launches the KBD read
    setFile("A\rB");
    applyStimulus(1'b0);
    waitReady(w);
    pollAndRead();
    waitReady(w);
    checkOutput("pace_char", w + 1, 7);
    pollAndRead();
    waitReady(w);
    checkOutput("pace_cr", w + 1, 23);
    pollAndRead();
    waitIdle();

    // KBDCR reads never consume
    setFile("a");
    applyStimulus(1'b0);
    waitReady(w);
    cs = 1'b1; enable = 1'b1; address = 1'b1;
    repeat (5) begin @(posedge clk25); #1; end
    cs = 1'b0; enable = 1'b0;
    checkOutput("kbdcr_keeps_ready", data_ready, 1);
    checkOutput("kbdcr_queue", expQ.size(), 1);
    pollAndRead();
    waitIdle();

    // Overflow: 20 bytes into a 16-byte buffer
    checkOutput("trunc_before", dut.truncated_q, 0);
    setFile("ABCDEFGHIJKLMNOPQRST");
    applyStimulus(1'b0);
    checkOutput("ovf_model_len", expQ.size(), 16);
    readAll(16);
    waitIdle();
    checkOutput("ovf_drained", expQ.size(), 0);
    checkOutput("trunc_after", dut.truncated_q, 1);

    // Abort while the 3rd character is pending
    setFile("HELLO");
    applyStimulus(1'b0);
    readAll(2);
    waitReady(w);
    ioctl_download = 1'b1;
    @(posedge clk25); #1;
    checkOutput("abort_ready", data_ready, 0);
    checkOutput("abort_busy", busy, 1);
    setFile("OK\r");
    applyStimulus(1'b0);
    readAll(3);
    waitIdle();
    checkOutput("abort_drained", expQ.size(), 0);

    // Reset while pacing
    setFile("XY");
    applyStimulus(1'b0);
    readAll(1);
    checkOutput("pace_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_pace_busy", busy, 0);
    checkOutput("rst_pace_dout", dout, 8'h00);
    checkOutput("rst_pace_ready", data_ready, 0);
    #2;
    rst = 1'b0;
    expQ.delete();
    repeat (10) @(posedge clk25);
    #1;
    checkOutput("post_rst_idle", busy, 0);
    checkOutput("post_rst_ready", data_ready, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
